// File: rtl/tenkey_tx.sv
// tenkey_tx: replays a latched multi-digit BCD PIN on a 10-bit one-hot keypad bus.
// Each digit is held for PRESS_CYC cycles and then released for GAP_CYC cycles.
// All outputs are registered. The pattern shown in a cycle is decoded from the
// state the FSM is entering, so it is valid in the first cycle of each slot.
//
// Ports:
//   clk    - clock; all logic is on the rising edge
//   rst_n  - asynchronous reset, active low
//   start  - send pin; sampled only in IDLE
//   abort  - cancel a sequence in progress; return to IDLE on the next cycle
//   pin    - DIGITS BCD nibbles; the most significant nibble is sent first
//   tenkey - one-hot key pattern; bit n means key n is pressed
//   busy   - a sequence is in progress
//   done   - one-cycle pulse when a sequence completes normally
//   err    - sticky; at least one digit of the current or last sequence was >9
module tenkey_tx #(
  parameter int DIGITS    = 4,
  parameter int PRESS_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [4*DIGITS-1:0]   pin,
  output logic [9:0]            tenkey,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int MAXC = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int IW   = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [IW-1:0]       idx, idx_d;
  logic [4*DIGITS-1:0] pin_q, pin_d;
  logic [9:0]          tenkey_d;
  logic                busy_d, done_d, err_d;
  logic [3:0]          cur_dig, nxt_dig;

  // Select digit i, where digit 0 is the most significant nibble. The loop
  // keeps every slice at a constant position.
  function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] p,
                                          input logic [IW-1:0] i);
    logic [3:0] d;
    d = '0;
    for (int k = 0; k < DIGITS; k++)
      if (i == IW'(k)) d = p[4*(DIGITS-1-k) +: 4];
    return d;
  endfunction

  assign cur_dig = digit_at(pin_q, idx);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    pin_d   = pin_q;
    done_d  = 1'b0;
    err_d   = err;
    case (state)
      IDLE: begin
        // abort has priority over start in the same cycle
        if (start && !abort) begin
          state_d = PRESS;
          cnt_d   = '0;
          idx_d   = '0;
          pin_d   = pin;
          err_d   = 1'b0;
        end
      end
      PRESS: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          // err becomes visible one cycle after the bad slot starts
          if (cur_dig > 4'd9) err_d = 1'b1;
          if (cnt == CW'(PRESS_CYC - 1)) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt == CW'(GAP_CYC - 1)) begin
          cnt_d = '0;
          if (idx == IW'(DIGITS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = PRESS;
            idx_d   = idx + IW'(1);
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they register in step with it.
  assign nxt_dig  = digit_at(pin_d, idx_d);
  assign busy_d   = (state_d != IDLE);
  assign tenkey_d = (state_d == PRESS && nxt_dig <= 4'd9) ? (10'd1 << nxt_dig) : 10'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      pin_q  <= '0;
      tenkey <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      pin_q  <= pin_d;
      tenkey <= tenkey_d;
      busy   <= busy_d;
      done   <= done_d;
      err    <= err_d;
    end
  end

endmodule

// File: tb/tb_tenkey_tx.sv
module tb_tenkey_tx;
  localparam int D = 4, P = 4, G = 2;
  localparam int L = D * (P + G);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] pin = '0;
  logic [9:0]  tenkey;
  logic        busy, done, err;

  logic        start2 = 1'b0, abort2 = 1'b0;
  logic [3:0]  pin2 = '0;
  logic [9:0]  tenkey2;
  logic        busy2, done2, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tenkey_tx #(.DIGITS(D), .PRESS_CYC(P), .GAP_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pin(pin),
    .tenkey(tenkey), .busy(busy), .done(done), .err(err));

  tenkey_tx #(.DIGITS(1), .PRESS_CYC(1), .GAP_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .pin(pin2),
    .tenkey(tenkey2), .busy(busy2), .done(done2), .err(err2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic chk_idle(input string tag, input logic exp_err);
    chk({tag, " tenkey"}, 32'(tenkey), 32'd0);
    chk({tag, " busy"},   32'(busy),   32'd0);
    chk({tag, " done"},   32'(done),   32'd0);
    chk({tag, " err"},    32'(err),    32'(exp_err));
  endtask

  // Called #1 after a clock edge, with the DUT idle or showing its done pulse.
  // start is raised for the current cycle (cycle 0). abort_cyc > 0 raises abort
  // during that cycle. inject raises start with a different pin while busy.
  task automatic send(input logic [15:0] p, input int abort_cyc, input bit inject);
    logic [9:0] etk[$];
    int         err_from;
    logic [3:0] d;
    logic       eerr;
    etk      = {};
    err_from = 1 << 30;
    // Reference: slot i starts at cycle i*(P+G)+1. A bad digit flags err one cycle later.
    for (int i = 0; i < D; i++) begin
      d = p[4*(D-1-i) +: 4];
      if (d > 9 && err_from == (1 << 30)) err_from = i * (P + G) + 2;
      for (int c = 0; c < P; c++) etk.push_back(d <= 9 ? (10'd1 << d) : 10'd0);
      for (int c = 0; c < G; c++) etk.push_back(10'd0);
    end
    pin   = p;
    start = 1'b1;
    for (int t = 1; t <= L + 1; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (abort_cyc > 0 && t > abort_cyc) begin
        chk_idle($sformatf("abort p=%h c%0d", p, t), abort_cyc >= err_from);
        if (t == abort_cyc + 3) break;
        continue;
      end
      eerr = (t >= err_from);
      if (t <= L) begin
        chk($sformatf("tenkey p=%h c%0d", p, t), 32'(tenkey), 32'(etk[t-1]));
        chk($sformatf("busy p=%h c%0d", p, t),   32'(busy),   32'd1);
        chk($sformatf("done p=%h c%0d", p, t),   32'(done),   32'd0);
        chk($sformatf("err p=%h c%0d", p, t),    32'(err),    32'(eerr));
      end else begin
        chk($sformatf("done-cycle tenkey p=%h", p), 32'(tenkey), 32'd0);
        chk($sformatf("done-cycle busy p=%h", p),   32'(busy),   32'd0);
        chk($sformatf("done-cycle done p=%h", p),   32'(done),   32'd1);
        chk($sformatf("done-cycle err p=%h", p),    32'(err),    32'(eerr));
      end
      if (t == abort_cyc) abort = 1'b1;
      if (inject && t == 3) begin
        start = 1'b1;
        pin   = 16'h5555;
      end
    end
  endtask

  initial begin
    logic [15:0] rp;
    logic [3:0]  nib;
    int          ac;

    // Reset values while rst_n is held low
    #1;
    chk_idle("reset", 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("post-reset idle", 1'b0);

    // Nominal sequence, then an invalid digit back-to-back, then a clearing run
    send(16'h1907, 0, 1'b0);
    send(16'h7A30, 0, 1'b0);
    chk("err held after done", 32'(err), 32'd1);
    send(16'h0000, 0, 1'b0);

    // abort in cycle 9 of the nominal case; done must not pulse
    send(16'h1907, 9, 1'b0);
    // abort on the same cycle as start in IDLE: start is ignored
    pin = 16'h1234; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk_idle("abort+start", 1'b0);

    // start with pin 5555 while busy is ignored
    send(16'h1907, 0, 1'b1);

    // Randomized sequences against the reference model
    for (int n = 0; n < 25; n++) begin
      rp = '0;
      for (int i = 0; i < D; i++) begin
        nib = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rp  = {rp[11:0], nib};
      end
      ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      send(rp, ac, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset during PRESS after err has been set
    send(16'h1907, 0, 1'b0);
    pin = 16'h7A30; start = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre-reset tenkey", 32'(tenkey), 32'd0);
    chk("pre-reset err",    32'(err),    32'd1);
    chk("pre-reset busy",   32'(busy),   32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async reset", 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      chk_idle($sformatf("after reset c%0d", t), 1'b0);
    end

    // 1-digit, 1-cycle press, 1-cycle gap
    pin2 = 4'h9; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    chk("sweep c1 tenkey", 32'(tenkey2), 32'h200);
    chk("sweep c1 busy",   32'(busy2),   32'd1);
    @(posedge clk); #1;
    chk("sweep c2 tenkey", 32'(tenkey2), 32'h0);
    chk("sweep c2 busy",   32'(busy2),   32'd1);
    chk("sweep c2 done",   32'(done2),   32'd0);
    @(posedge clk); #1;
    chk("sweep c3 done",   32'(done2),   32'd1);
    chk("sweep c3 busy",   32'(busy2),   32'd0);
    chk("sweep c3 err",    32'(err2),    32'd0);
    pin2 = 4'hC; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    chk("sweep bad c1 tenkey", 32'(tenkey2), 32'h0);
    chk("sweep bad c1 err",    32'(err2),    32'd0);
    @(posedge clk); #1;
    chk("sweep bad c2 err",    32'(err2),    32'd1);
    @(posedge clk); #1;
    chk("sweep bad c3 done",   32'(done2),   32'd1);
    chk("sweep bad c3 err",    32'(err2),    32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
